// File: rtl/dz_rx_silo.sv
// dz_rx_silo: receive silo for a multi-line DZ-style serial interface.
// A round-robin scanner moves characters from the line receivers into a shared
// FIFO tagged with line number and error flags; the FIFO head is presented as
// RBUF. Adds per-line receive enable, a silo-alarm threshold and a timeout.
module dz_rx_silo #(
    parameter int NLINES   = 8,
    parameter int DEPTH    = 64,
    parameter int SATHRESH = 16,
    parameter int TIMEOUT  = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     csrMSE,
    input  logic                     csrSAE,
    input  logic [NLINES-1:0]        rxENAB,
    input  logic [NLINES-1:0]        uartRXFULL,
    input  logic [NLINES-1:0]        uartRXFRME,
    input  logic [NLINES-1:0]        uartRXPARE,
    input  logic [NLINES*8-1:0]      uartRXDATA,
    output logic [NLINES-1:0]        uartRXCLR,
    input  logic                     rbufREAD,
    output logic                     rbufRDONE,
    output logic                     rbufSA,
    output logic [$clog2(DEPTH):0]   siloCOUNT,
    output logic [15:0]              regRBUF
);

    localparam int LW = $clog2(NLINES);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = 11 + LW;
    localparam int SW = $clog2(SATHRESH + 1);
    localparam int TW = $clog2(TIMEOUT + 2);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] SA_MAX   = SW'(SATHRESH);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT);

    logic [LW-1:0] idx;
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          ovr;
    logic          rd_q;
    logic [SW-1:0] sa_cnt;
    logic [TW-1:0] tmr;
    logic [TW-1:0] tmr_nxt;
    logic          sa_q;

    logic          init;
    logic          hit;
    logic          wr_req;
    logic          pop;
    logic          pop_eff;
    logic          full;
    logic          empty;
    logic          wr_eff;
    logic          drop;
    logic [EW-1:0] entry;
    logic [EW-1:0] head;

    assign init    = rst | clr;
    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign hit     = !init && csrMSE && uartRXFULL[idx];
    assign wr_req  = hit && rxENAB[idx];
    // A bus read pops once, on the first cycle after rbufREAD drops.
    assign pop     = !init && rd_q && !rbufREAD;
    assign pop_eff = pop && !empty;
    // A pop in the same cycle frees the slot, so a write to a full silo still lands.
    assign wr_eff  = wr_req && (!full || pop_eff);
    assign drop    = wr_req && full && !pop_eff;
    assign entry   = {ovr, uartRXFRME[idx], uartRXPARE[idx], idx, uartRXDATA[idx*8 +: 8]};
    assign head    = mem[rd_ptr];

    assign rbufRDONE = !empty;
    assign rbufSA    = sa_q;
    assign siloCOUNT = count;

    // Receiver clear and RBUF formatting from the current scan slot and FIFO head.
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
    always_comb begin
        uartRXCLR = '0;
        if (hit) uartRXCLR[idx] = 1'b1;
        regRBUF = '0;
        if (!empty) begin
            regRBUF[15]       = 1'b1;
            regRBUF[14:12]    = head[EW-1 -: 3];
            regRBUF[LW+7:0]   = head[LW+7:0];
        end
    end

    // Scanner, FIFO pointers/occupancy and the sticky overrun flag.
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (init) begin
            idx    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovr    <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            rd_q <= rbufREAD;
            if (csrMSE) idx <= idx + 1'b1;
            if (wr_eff) wr_ptr <= wr_ptr + 1'b1;
            if (pop_eff) rd_ptr <= rd_ptr + 1'b1;
            if (wr_eff && !pop_eff)      count <= count + 1'b1;
            else if (!wr_eff && pop_eff) count <= count - 1'b1;
            if (wr_eff)    ovr <= 1'b0;
            else if (drop) ovr <= 1'b1;
        end
    end

    // FIFO storage.
    // NOTE: the data array is deliberately not reset; occupancy and pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (wr_eff) mem[wr_ptr] <= entry;
    end

    // Next timeout count: runs while the alarm is enabled and data waits unread.
    always_comb begin
        tmr_nxt = tmr;
        if (!csrSAE || pop || empty) tmr_nxt = '0;
        else if (tmr != TO_MAX)      tmr_nxt = tmr + 1'b1;
    end

    // Silo alarm: write-count threshold and no-pop timeout, both gated by csrSAE.
    always_ff @(posedge clk) begin
        if (init || !csrSAE || pop) begin
            sa_cnt <= '0;
            tmr    <= '0;
            sa_q   <= 1'b0;
        end else begin
            tmr <= tmr_nxt;
            if (wr_eff && sa_cnt != SA_MAX) sa_cnt <= sa_cnt + 1'b1;
            if (sa_cnt == SA_MAX || (TIMEOUT > 0 && tmr_nxt == TO_MAX)) sa_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dz_rx_silo.sv
// Self-checking bench for dz_rx_silo: a queue-based reference model follows
// every clock, and directed steps exercise scan, enable, overrun, alarm,
// timeout and reset behaviour with randomized characters.
module tb_dz_rx_silo;

    localparam int NLINES   = 8;
    localparam int DEPTH    = 64;
    localparam int SATHRESH = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst, clr, csrMSE, csrSAE, sae2, rbufREAD;
    logic [NLINES-1:0]    rxENAB, uartRXFULL, uartRXFRME, uartRXPARE;
    logic [NLINES*8-1:0]  uartRXDATA;
    logic [NLINES-1:0]    uartRXCLR, clr2;
    logic                 rbufRDONE, rbufSA, rdone2, sa2;
    logic [6:0]           siloCOUNT, count2;
    logic [15:0]          regRBUF, rbuf2;

    dz_rx_silo #(.NLINES(NLINES), .DEPTH(DEPTH), .SATHRESH(SATHRESH), .TIMEOUT(0)) dut (
        .clk(clk), .rst(rst), .clr(clr), .csrMSE(csrMSE), .csrSAE(csrSAE),
        .rxENAB(rxENAB), .uartRXFULL(uartRXFULL), .uartRXFRME(uartRXFRME),
        .uartRXPARE(uartRXPARE), .uartRXDATA(uartRXDATA), .uartRXCLR(uartRXCLR),
        .rbufREAD(rbufREAD), .rbufRDONE(rbufRDONE), .rbufSA(rbufSA),
        .siloCOUNT(siloCOUNT), .regRBUF(regRBUF)
    );

    // Second instance with the alarm timeout enabled; shares all stimulus except csrSAE.
    dz_rx_silo #(.NLINES(NLINES), .DEPTH(DEPTH), .SATHRESH(SATHRESH), .TIMEOUT(100)) dut_to (
        .clk(clk), .rst(rst), .clr(clr), .csrMSE(csrMSE), .csrSAE(sae2),
        .rxENAB(rxENAB), .uartRXFULL(uartRXFULL), .uartRXFRME(uartRXFRME),
        .uartRXPARE(uartRXPARE), .uartRXDATA(uartRXDATA), .uartRXCLR(clr2),
        .rbufREAD(rbufREAD), .rbufRDONE(rdone2), .rbufSA(sa2),
        .siloCOUNT(count2), .regRBUF(rbuf2)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model state
    logic [15:0] q[$];
    bit          m_ovr;
    int          m_idx;
    bit          m_rdq;
    int          m_sacnt;
    bit          m_sa;
    int          last_wr_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] fmt(bit o, bit f, bit p, int line, logic [7:0] d);
        return {1'b1, o, f, p, 4'(line), d};
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovr   = 1'b0;
        m_idx   = 0;
        m_rdq   = 1'b0;
        m_sacnt = 0;
        m_sa    = 1'b0;
    endtask

    // One clock: check the combinational clear, advance the model, check outputs.
    task automatic step();
        bit                hit, wr, pop, sa_n;
        int                s;
        logic [NLINES-1:0] exp_clr;
        #1;
        s       = m_idx;
        hit     = !rst && !clr && csrMSE && uartRXFULL[s];
        exp_clr = hit ? (NLINES'(1) << s) : '0;
        check("uartRXCLR", 32'(uartRXCLR), 32'(exp_clr));
        wr  = hit && rxENAB[s];
        pop = m_rdq && !rbufREAD;
        @(posedge clk);
        cyc++;
        if (rst || clr) begin
            model_reset();
        end else begin
            sa_n = csrSAE && !pop && (m_sa || m_sacnt == SATHRESH);
            if (pop && q.size() > 0) void'(q.pop_front());
            if (wr) begin
                if (q.size() < DEPTH) begin
                    q.push_back(fmt(m_ovr, uartRXFRME[s], uartRXPARE[s], s, uartRXDATA[s*8 +: 8]));
                    m_ovr       = 1'b0;
                    last_wr_cyc = cyc;
                    if (m_sacnt < SATHRESH) m_sacnt++;
                end else begin
                    m_ovr = 1'b1;
                end
            end
            if (!csrSAE || pop) m_sacnt = 0;
            m_sa  = sa_n;
            m_rdq = rbufREAD;
            if (csrMSE) m_idx = (m_idx + 1) % NLINES;
        end
        @(negedge clk);
        if (hit) uartRXFULL[s] = 1'b0;
        check("regRBUF", 32'(regRBUF), (q.size() > 0) ? 32'(q[0]) : 32'h0);
        check("siloCOUNT", 32'(siloCOUNT), 32'(q.size()));
        check("rbufRDONE", 32'(rbufRDONE), 32'(q.size() > 0));
        check("rbufSA", 32'(rbufSA), 32'(m_sa));
    endtask

    // Present a character on one line and wait (bounded) for the scanner to take it.
    task automatic send(input int line, input logic [7:0] d, input bit fe, input bit pe);
        uartRXDATA[line*8 +: 8] = d;
        uartRXFRME[line]        = fe;
        uartRXPARE[line]        = pe;
        uartRXFULL[line]        = 1'b1;
        for (int i = 0; i < 4 * NLINES && uartRXFULL[line]; i++) step();
        check("scan_taken", 32'(uartRXFULL[line]), 32'h0);
    endtask

    task automatic send_rand();
        send(int'($urandom_range(0, NLINES - 1)), 8'($urandom_range(0, 255)),
             bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
    endtask

    task automatic read_pulse();
        rbufREAD = 1'b1;
        step();
        step();
        rbufREAD = 1'b0;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int s, delta;
        bit seen;
        rst = 1'b1; clr = 1'b0; csrMSE = 1'b1; csrSAE = 1'b0; sae2 = 1'b0; rbufREAD = 1'b0;
        rxENAB = '1; uartRXFULL = '0; uartRXFRME = '0; uartRXPARE = '0; uartRXDATA = '0;
        model_reset();
        @(negedge clk);
        step();
        step();
        rst = 1'b0;
        check("reset_rbuf", 32'(regRBUF), 32'h0);
        check("reset_count", 32'(siloCOUNT), 32'h0);

        // 1: framed character on line 5
        send(5, 8'h41, 1'b1, 1'b0);
        check("t1_rbuf", 32'(regRBUF), 32'hA541);
        check("t1_count", 32'(siloCOUNT), 32'd1);
        read_pulse();
        step();
        check("t1_rdone", 32'(rbufRDONE), 32'h0);
        check("t1_rbuf_empty", 32'(regRBUF), 32'h0);

        // 2: disabled line is cleared but not stored
        rxENAB[3] = 1'b0;
        send(3, 8'h99, 1'b0, 1'b1);
        step();
        check("t2_count", 32'(siloCOUNT), 32'h0);
        rxENAB = '1;

        // 3: fill, overrun, and the OVRE tag on the next stored character
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_rand();
        check("t3_full", 32'(siloCOUNT), 32'd64);
        send_rand();
        send_rand();
        check("t3_still_full", 32'(siloCOUNT), 32'd64);
        read_pulse();
        send(2, 8'h55, 1'b0, 1'b0);
        read_pulse();
        send_rand();
        for (int k = 0; k < DEPTH; k++) begin
            check("t3_ovre", 32'(regRBUF[14]), 32'(k == 62));
            if (k == 62) check("t3_ovr_entry", 32'(regRBUF[10:0]), 32'h255);
            read_pulse();
        end
        check("t3_drained", 32'(siloCOUNT), 32'h0);

        // 4: alarm threshold
        do_reset();
        csrSAE = 1'b1;
        for (int i = 0; i < SATHRESH - 1; i++) send_rand();
        step(); step(); step();
        check("t4_sa_15", 32'(rbufSA), 32'h0);
        send_rand();
        check("t4_sa_before", 32'(rbufSA), 32'h0);
        step();
        check("t4_sa_16", 32'(rbufSA), 32'h1);
        read_pulse();
        check("t4_sa_read", 32'(rbufSA), 32'h0);
        for (int i = 0; i < SATHRESH; i++) send_rand();
        step();
        check("t4_sa_again", 32'(rbufSA), 32'h1);
        csrSAE = 1'b0;
        step();
        check("t4_sa_disable", 32'(rbufSA), 32'h0);

        // 5: alarm timeout (second instance), and a read that cancels it
        do_reset();
        csrSAE = 1'b1;
        sae2   = 1'b1;
        send_rand();
        delta = -1;
        for (int i = 0; i < 200 && delta < 0; i++) begin
            step();
            if (sa2 === 1'b1) delta = cyc - last_wr_cyc;
        end
        check("t5_timeout_latency", 32'(delta), 32'd100);
        do_reset();
        send_rand();
        for (int i = 0; i < 50; i++) step();
        read_pulse();
        seen = 1'b0;
        for (int i = 0; i < 150; i++) begin
            step();
            if (sa2 !== 1'b0) seen = 1'b1;
        end
        check("t5_timeout_cancel", 32'(seen), 32'h0);
        sae2   = 1'b0;
        csrSAE = 1'b0;

        // 6: simultaneous pop and write on a full silo
        do_reset();
        for (int i = 0; i < DEPTH; i++) send_rand();
        rbufREAD = 1'b1;
        step();
        step();
        rbufREAD = 1'b0;
        s = m_idx;
        uartRXDATA[s*8 +: 8] = 8'($urandom_range(0, 255));
        uartRXFULL[s] = 1'b1;
        step();
        check("t6_both_taken", 32'(uartRXFULL[s]), 32'h0);
        check("t6_count", 32'(siloCOUNT), 32'd64);
        for (int k = 0; k < DEPTH; k++) begin
            check("t6_no_ovre", 32'(regRBUF[14]), 32'h0);
            read_pulse();
        end

        // 6: reset and clear mid-scan
        for (int i = 0; i < 3; i++) send_rand();
        s = m_idx;
        uartRXFULL[s] = 1'b1;
        rst = 1'b1;
        #1;
        check("t6_rst_clr_comb", 32'(uartRXCLR), 32'h0);
        step();
        check("t6_rst_rbuf", 32'(regRBUF), 32'h0);
        check("t6_rst_count", 32'(siloCOUNT), 32'h0);
        check("t6_rst_rdone", 32'(rbufRDONE), 32'h0);
        check("t6_rst_sa", 32'(rbufSA), 32'h0);
        check("t6_rst_rxclr", 32'(uartRXCLR), 32'h0);
        rst = 1'b0;
        uartRXFULL = '0;
        send_rand();
        send_rand();
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("t6_clr_count", 32'(siloCOUNT), 32'h0);
        check("t6_clr_rbuf", 32'(regRBUF), 32'h0);
        send(7, 8'hC3, 1'b0, 1'b1);
        check("t6_after_clr", 32'(regRBUF), 32'h97C3);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
